// File: rtl/mem_arbiter_pkg.sv
// Shared types, sizes and helpers for the processor-pool memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned PROC_COUNT  = 4;
  localparam int unsigned BUS_W       = 128;
  localparam int unsigned ELEM_W      = BUS_W / 8;
  localparam int unsigned BE_W        = BUS_W / 8;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned IDX_W       = $clog2(PROC_COUNT);
  localparam int unsigned MEM_LAT_DEF = 2;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [PROC_COUNT-1:0] proc_vec_t;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;

  // Command presented on the shared memory port
  typedef struct packed {
    addr_t             addr;
    logic [BUS_W-1:0]  wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

  // Element count minus one -> contiguous low byte enables
  function automatic logic [BE_W-1:0] wr_size_to_be(input logic [2:0] size);
    return BE_W'((32'd1 << ((32'(size) + 32'd1) * (ELEM_W / 8))) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pool-side request/grant bus plus the shared memory port of the arbiter.
interface mem_arbiter_if import mem_arbiter_pkg::*; ();

  proc_vec_t                        i_req_rd;
  proc_vec_t                        i_req_wr;
  addr_t     [PROC_COUNT-1:0]       i_addr;
  logic      [PROC_COUNT-1:0][BUS_W-1:0] i_wdata;
  proc_vec_t                        i_wr_en;
  logic      [PROC_COUNT-1:0][2:0]  i_wr_size;
  proc_vec_t                        o_grant_rd;
  proc_vec_t                        o_grant_wr;
  logic      [BUS_W-1:0]            o_data;
  addr_t                            o_mem_addr;
  logic      [BUS_W-1:0]            o_mem_wdata;
  logic                             o_mem_we;
  logic      [BE_W-1:0]             o_mem_be;
  logic                             o_mem_re;
  logic      [BUS_W-1:0]            i_mem_rdata;

  modport slave (
    input  i_req_rd, i_req_wr, i_addr, i_wdata, i_wr_en, i_wr_size, i_mem_rdata,
    output o_grant_rd, o_grant_wr, o_data, o_mem_addr, o_mem_wdata, o_mem_we,
           o_mem_be, o_mem_re
  );

  modport master (
    output i_req_rd, i_req_wr, i_addr, i_wdata, i_wr_en, i_wr_size, i_mem_rdata,
    input  o_grant_rd, o_grant_wr, o_data, o_mem_addr, o_mem_wdata, o_mem_we,
           o_mem_be, o_mem_re
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter import mem_arbiter_pkg::*; (
  input  proc_vec_t req,
  input  idx_t      ptr,
  output proc_vec_t grant_c,
  output idx_t      idx_c,
  output logic      valid_c
);

  idx_t cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < PROC_COUNT; k++) begin
      cand = IDX_W'((32'(ptr) + k) % PROC_COUNT);
      if (!valid_c && req[cand]) begin
        valid_c       = 1'b1;
        idx_c         = cand;
        grant_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates per-processor read/write requests onto one shared memory port.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t       state_q, state_d;
  idx_t             ptr_q, ptr_d, idx_q, idx_d;
  logic             op_wr_q, op_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  proc_vec_t        grant_rd_q, grant_rd_d, grant_wr_q, grant_wr_d;
  logic             we_q, we_d, re_q, re_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [BUS_W-1:0] data_q, data_d;

  proc_vec_t        req_any_c, arb_grant_c;
  idx_t             arb_idx_c, next_ptr_c;
  logic             arb_valid_c, win_wr_c;

  assign req_any_c = bus.i_req_rd | bus.i_req_wr;

  rr_arbiter u_rr (
    .req     (req_any_c),
    .ptr     (ptr_q),
    .grant_c (arb_grant_c),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  // A winner holding both requests is served as a write first
  assign win_wr_c   = bus.i_req_wr[arb_idx_c];
  assign next_ptr_c = (32'(idx_q) == PROC_COUNT - 1) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    op_wr_d    = op_wr_q;
    cnt_d      = cnt_q;
    grant_rd_d = '0;
    grant_wr_d = '0;
    we_d       = 1'b0;
    re_d       = 1'b0;
    cmd_d      = cmd_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_c) begin
          idx_d       = arb_idx_c;
          op_wr_d     = win_wr_c;
          cmd_d.addr  = bus.i_addr[arb_idx_c];
          cmd_d.wdata = bus.i_wdata[arb_idx_c];
          cmd_d.be    = wr_size_to_be(bus.i_wr_size[arb_idx_c]);
          we_d        = win_wr_c & bus.i_wr_en[arb_idx_c];
          re_d        = ~win_wr_c;
          grant_wr_d  = win_wr_c ? arb_grant_c : '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (op_wr_q) begin
          ptr_d   = next_ptr_c;
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d     = bus.i_mem_rdata;
          grant_rd_d = PROC_COUNT'(1'b1) << idx_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        ptr_d   = next_ptr_c;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      op_wr_q    <= 1'b0;
      cnt_q      <= '0;
      grant_rd_q <= '0;
      grant_wr_q <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cmd_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      op_wr_q    <= op_wr_d;
      cnt_q      <= cnt_d;
      grant_rd_q <= grant_rd_d;
      grant_wr_q <= grant_wr_d;
      we_q       <= we_d;
      re_q       <= re_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
    end
  end

  assign bus.o_grant_rd  = grant_rd_q;
  assign bus.o_grant_wr  = grant_wr_q;
  assign bus.o_data      = data_q;
  assign bus.o_mem_addr  = cmd_q.addr;
  assign bus.o_mem_wdata = cmd_q.wdata;
  assign bus.o_mem_be    = cmd_q.be;
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_re    = re_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, expected bus events queued.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned LAT = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 write access, 1 read access, 2 read response
  typedef struct {
    string            name;
    int               kind;
    int               cyc;
    proc_vec_t        grd;
    proc_vec_t        gwr;
    logic             we;
    logic             re;
    addr_t            addr;
    logic [BE_W-1:0]  be;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic ok;

  function automatic void push_write(input string nm, input int c, input proc_vec_t g,
                                     input logic we, input addr_t a, input logic [BE_W-1:0] be,
                                     input logic [BUS_W-1:0] d);
    exp_t x;
    x = '{name: nm, kind: 0, cyc: c, grd: '0, gwr: g, we: we, re: 1'b0,
          addr: a, be: be, wdata: d, rdata: '0};
    sb.push_back(x);
  endfunction

  function automatic void push_read(input string nm, input int c_acc, input proc_vec_t g,
                                    input addr_t a, input logic [BUS_W-1:0] d);
    exp_t x;
    x = '{name: {nm, "_acc"}, kind: 1, cyc: c_acc, grd: '0, gwr: '0, we: 1'b0, re: 1'b1,
          addr: a, be: '0, wdata: '0, rdata: '0};
    sb.push_back(x);
    x = '{name: {nm, "_rsp"}, kind: 2, cyc: c_acc + int'(LAT) + 1, grd: g, gwr: '0, we: 1'b0,
          re: 1'b0, addr: '0, be: '0, wdata: '0, rdata: d};
    sb.push_back(x);
  endfunction

  // Monitor: every grant or strobe cycle must match the head of the scoreboard
  initial forever begin
    @(negedge clk);
    if ((bus.o_grant_rd != '0) || (bus.o_grant_wr != '0) || bus.o_mem_we || bus.o_mem_re) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got cyc=%0d grd=%b gwr=%b we=%b re=%b, want no event",
                 cyc, bus.o_grant_rd, bus.o_grant_wr, bus.o_mem_we, bus.o_mem_re);
      end else begin
        e  = sb.pop_front();
        ok = (cyc == e.cyc) && (bus.o_grant_rd == e.grd) && (bus.o_grant_wr == e.gwr) &&
             (bus.o_mem_we == e.we) && (bus.o_mem_re == e.re);
        if (e.kind == 0)
          ok = ok && (bus.o_mem_addr == e.addr) && (bus.o_mem_be == e.be) &&
               (bus.o_mem_wdata == e.wdata);
        else if (e.kind == 1)
          ok = ok && (bus.o_mem_addr == e.addr);
        else
          ok = ok && (bus.o_data == e.rdata);
        if (!ok) begin
          n_err++;
          $display("FAIL %s: got cyc=%0d grd=%b gwr=%b we=%b re=%b addr=%h be=%h wd=%h rd=%h; want cyc=%0d grd=%b gwr=%b we=%b re=%b addr=%h be=%h wd=%h rd=%h",
                   e.name, cyc, bus.o_grant_rd, bus.o_grant_wr, bus.o_mem_we, bus.o_mem_re,
                   bus.o_mem_addr, bus.o_mem_be, bus.o_mem_wdata, bus.o_data,
                   e.cyc, e.grd, e.gwr, e.we, e.re, e.addr, e.be, e.wdata, e.rdata);
        end
      end
    end
  end

  // Memory model: data valid LAT cycles after the read strobe, junk otherwise
  logic  re_hist [LAT+1];
  addr_t a_hist  [LAT+1];

  function automatic logic [BUS_W-1:0] mem_word(input addr_t a);
    return (a == 16'h0020) ? {8{16'hDEAD}} : {8{a ^ 16'h5A5A}};
  endfunction

  initial begin
    bus.i_mem_rdata = '0;
    for (int k = 0; k <= int'(LAT); k++) begin
      re_hist[k] = 1'b0;
      a_hist[k]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = int'(LAT); k > 0; k--) begin
        re_hist[k] = re_hist[k-1];
        a_hist[k]  = a_hist[k-1];
      end
      re_hist[0] = bus.o_mem_re;
      a_hist[0]  = bus.o_mem_addr;
      bus.i_mem_rdata = re_hist[LAT] ? mem_word(a_hist[LAT]) : {8{16'hBAD0}};
    end
  end

  task automatic check_val(input string nm, input logic [BUS_W-1:0] act,
                           input logic [BUS_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    #1;
    check_val({nm, "_grant_rd"}, BUS_W'(bus.o_grant_rd), '0);
    check_val({nm, "_grant_wr"}, BUS_W'(bus.o_grant_wr), '0);
    check_val({nm, "_we"},       BUS_W'(bus.o_mem_we), '0);
    check_val({nm, "_re"},       BUS_W'(bus.o_mem_re), '0);
    check_val({nm, "_be"},       BUS_W'(bus.o_mem_be), '0);
    check_val({nm, "_addr"},     BUS_W'(bus.o_mem_addr), '0);
    check_val({nm, "_wdata"},    bus.o_mem_wdata, '0);
    check_val({nm, "_data"},     bus.o_data, '0);
  endtask

  task automatic issue(input int p, input logic rd, input logic wr, input addr_t a,
                       input logic [BUS_W-1:0] d, input logic [2:0] sz, input logic en);
    bus.i_addr[p]    = a;
    bus.i_wdata[p]   = d;
    bus.i_wr_size[p] = sz;
    bus.i_wr_en[p]   = en;
    if (rd) bus.i_req_rd[p] = 1'b1;
    if (wr) bus.i_req_wr[p] = 1'b1;
  endtask

  // Pool behaviour: drop each request right after its grant, until all are served
  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (((bus.i_req_rd | bus.i_req_wr) != '0) && t < 300) begin
      @(negedge clk);
      bus.i_req_wr = bus.i_req_wr & ~bus.o_grant_wr;
      bus.i_req_rd = bus.i_req_rd & ~bus.o_grant_rd;
      t++;
    end
    if (t >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got pending rd=%b wr=%b, want none", nm, bus.i_req_rd, bus.i_req_wr);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [BUS_W-1:0] rd4 [4];
    rd4[0] = {8{16'h5A1A}};
    rd4[1] = {8{16'h5A1B}};
    rd4[2] = {8{16'h5A18}};
    rd4[3] = {8{16'h5A19}};

    bus.i_req_rd  = '0;
    bus.i_req_wr  = '0;
    bus.i_addr    = '0;
    bus.i_wdata   = '0;
    bus.i_wr_en   = '0;
    bus.i_wr_size = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single write, size 3
    n = cyc;
    issue(1, 1'b0, 1'b1, 16'h0010, {8{16'hA5A5}}, 3'd3, 1'b1);
    push_write("wr_p1", n + 1, 4'b0010, 1'b1, 16'h0010, 16'h00FF, {8{16'hA5A5}});
    wait_idle("wr_p1");

    // Single read
    n = cyc;
    issue(2, 1'b1, 1'b0, 16'h0020, '0, 3'd0, 1'b0);
    push_read("rd_p2", n + 1, 4'b0100, 16'h0020, {8{16'hDEAD}});
    wait_idle("rd_p2");

    // Reset while idle clears the held read data and the pointer
    rstn = 1'b0;
    check_reset_outputs("rst1");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // All four read at once: served 0,1,2,3 every LAT+3 cycles
    n = cyc;
    for (int k = 0; k < 4; k++)
      issue(k, 1'b1, 1'b0, addr_t'(16'h0040 + k), '0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++)
      push_read($sformatf("rd4_p%0d", k), n + 1 + 5 * k, proc_vec_t'(4'b0001 << k),
                addr_t'(16'h0040 + k), rd4[k]);
    wait_idle("rd4");

    // Proc 0 with both requests and wr_en low: write first (no commit), then read
    n = cyc;
    issue(0, 1'b1, 1'b1, 16'h0030, {8{16'h1234}}, 3'd1, 1'b0);
    push_write("rw_p0_wr", n + 1, 4'b0001, 1'b0, 16'h0030, 16'h000F, {8{16'h1234}});
    push_read("rw_p0_rd", n + 3, 4'b0001, 16'h0030, {8{16'h5A6A}});
    wait_idle("rw_p0");

    // Size 0 write by proc 2 leaves the pointer at 3
    n = cyc;
    issue(2, 1'b0, 1'b1, 16'h0050, {8{16'h0F0F}}, 3'd0, 1'b1);
    push_write("wr_p2_sz0", n + 1, 4'b0100, 1'b1, 16'h0050, 16'h0003, {8{16'h0F0F}});
    wait_idle("wr_p2_sz0");

    // Wrap: procs 3 and 0 together, 3 first
    n = cyc;
    issue(3, 1'b0, 1'b1, 16'h0060, {8{16'hC3C3}}, 3'd7, 1'b1);
    issue(0, 1'b0, 1'b1, 16'h0061, {8{16'h3C3C}}, 3'd2, 1'b1);
    push_write("wrap_p3_sz7", n + 1, 4'b1000, 1'b1, 16'h0060, 16'hFFFF, {8{16'hC3C3}});
    push_write("wrap_p0_sz2", n + 3, 4'b0001, 1'b1, 16'h0061, 16'h003F, {8{16'h3C3C}});
    wait_idle("wrap");

    // Reset during WAIT: read abandoned, then re-arbitration from proc 0
    n = cyc;
    issue(2, 1'b1, 1'b0, 16'h0020, '0, 3'd0, 1'b0);
    push_write("abort_p2_dummy", -1, '0, 1'b0, '0, '0, '0);
    void'(sb.pop_back());
    begin
      exp_t x;
      x = '{name: "abort_p2_acc", kind: 1, cyc: n + 1, grd: '0, gwr: '0, we: 1'b0, re: 1'b1,
            addr: 16'h0020, be: '0, wdata: '0, rdata: '0};
      sb.push_back(x);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    issue(0, 1'b1, 1'b0, 16'h0071, '0, 3'd0, 1'b0);
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n = cyc;
    push_read("post_rst_p0", n + 1, 4'b0001, 16'h0071, {8{16'h5A2B}});
    push_read("post_rst_p2", n + 6, 4'b0100, 16'h0020, {8{16'hDEAD}});
    wait_idle("post_rst");

    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drained: got %0d pending events, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
